// File: rtl/fetch_pc_if.sv
// Fetch sequencer bus: start/branch/stall controls in, ROM address and status out.
// The slave modport is the fetch_pc side; the master modport is the controlling side.
interface fetch_pc_if #(
  parameter int unsigned A = 10,
  parameter int unsigned W = 9
);
  logic         start;
  logic [A-1:0] start_addr;
  logic         stall;
  logic         branch_en;
  logic         branch_abs;
  logic [A-1:0] target;
  logic [W-1:0] inst_in;
  logic [A-1:0] inst_address;
  logic         valid;
  logic         busy;
  logic         done;
  logic [15:0]  cycle_count;

  modport slave (
    input  start, start_addr, stall, branch_en, branch_abs, target, inst_in,
    output inst_address, valid, busy, done, cycle_count
  );

  modport master (
    output start, start_addr, stall, branch_en, branch_abs, target, inst_in,
    input  inst_address, valid, busy, done, cycle_count
  );
endinterface

// File: rtl/fetch_pc.sv
// Program counter and fetch sequencer with halt detection, stall and branch redirection.
// Optional run-cycle counter enabled by defining FETCH_PC_CYCLE_CNT_EN.
module fetch_pc #(
  parameter int unsigned    A         = 10,
  parameter int unsigned    W         = 9,
  parameter logic [W-1:0]   HALT_WORD = '1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  fetch_pc_if.slave   fetch_io
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e       state_q, state_d;
  logic [A-1:0] pc_q, pc_d;
  logic         load_start;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    load_start = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (fetch_io.start) begin
          load_start = 1'b1;
          pc_d       = fetch_io.start_addr;
          state_d    = StRun;
        end
      end
      StRun: begin
        if (fetch_io.stall) begin
          pc_d = pc_q;
        end else if (fetch_io.inst_in == HALT_WORD) begin
          state_d = StDone;
        end else if (fetch_io.branch_en) begin
          // Modular A-bit add gives the signed-offset result directly.
          pc_d = fetch_io.branch_abs ? fetch_io.target : pc_q + fetch_io.target;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign fetch_io.inst_address = pc_q;
  assign fetch_io.valid        = (state_q == StRun);
  assign fetch_io.busy         = (state_q == StRun);
  assign fetch_io.done         = (state_q == StDone);

`ifdef FETCH_PC_CYCLE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts every RUN cycle, stalls and the halt-detect cycle included; saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (load_start) begin
      cnt_d = '0;
    end else if (state_q == StRun && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_io.cycle_count = cnt_q;
`else
  logic unused_load_start;
  assign unused_load_start    = load_start;
  assign fetch_io.cycle_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc: table of single-step control vectors plus
// hand-written multi-cycle sequences, compared through an expected-value queue.
module tb_fetch_pc;

  logic clk;
  logic rst;
  logic       use_rom;
  logic [8:0] inst_force;
  logic [8:0] rom [1024];

  fetch_pc_if #(.A(10), .W(9)) bus ();

  fetch_pc #(.A(10), .W(9), .HALT_WORD(9'h1FF)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .fetch_io (bus)
  );

  assign bus.inst_in = use_rom ? rom[bus.inst_address] : inst_force;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] pc;
    logic       valid;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    string      name;
    logic [9:0] pc0;
    logic       start;
    logic       stall;
    logic       br_en;
    logic       br_abs;
    logic [9:0] tgt;
    logic [8:0] inst;
    logic [9:0] exp_pc;
    logic       exp_done;
  } vec_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  vec_t  vecs[9];

`ifdef FETCH_PC_CYCLE_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_obs(input string name, input logic [9:0] pc, input logic v,
                            input logic b, input logic d);
    obs_t e;
    e.pc = pc; e.valid = v; e.busy = b; e.done = d;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic check_obs();
    obs_t  e, a;
    string nm;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    a.pc = bus.inst_address; a.valid = bus.valid; a.busy = bus.busy; a.done = bus.done;
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got pc=%0d valid=%b busy=%b done=%b, want pc=%0d valid=%b busy=%b done=%b",
               nm, a.pc, a.valid, a.busy, a.done, e.pc, e.valid, e.busy, e.done);
    end
  endtask

  task automatic check_cnt(input string name, input logic [15:0] exp);
    n_vec++;
    if (bus.cycle_count !== exp) begin
      n_err++;
      $display("FAIL %s: got cycle_count=%0d, want %0d", name, bus.cycle_count, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.start_addr = '0; bus.stall = 1'b0;
    bus.branch_en = 1'b0; bus.branch_abs = 1'b0; bus.target = '0;
    inst_force = 9'h000; use_rom = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic start_run(input logic [9:0] addr);
    bus.start_addr = addr;
    bus.start      = 1'b1;
    step();
    bus.start      = 1'b0;
  endtask

  task automatic set_vec(input int i, input string name, input logic [9:0] pc0,
                         input logic start, input logic stall, input logic br_en,
                         input logic br_abs, input logic [9:0] tgt, input logic [8:0] inst,
                         input logic [9:0] exp_pc, input logic exp_done);
    vecs[i].name = name; vecs[i].pc0 = pc0; vecs[i].start = start; vecs[i].stall = stall;
    vecs[i].br_en = br_en; vecs[i].br_abs = br_abs; vecs[i].tgt = tgt; vecs[i].inst = inst;
    vecs[i].exp_pc = exp_pc; vecs[i].exp_done = exp_done;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
    for (int i = 0; i < 4; i++) rom[i] = 9'h010 + 9'(i);
    rom[4] = 9'h1FF;

    //      name            pc0   st stl ben abs tgt      inst    exp_pc done
    set_vec(0, "br_rel_neg", 10'd10,   0, 0, 1, 0, 10'h3FE, 9'h000, 10'd8,   0);
    set_vec(1, "br_abs",     10'd8,    0, 0, 1, 1, 10'd100, 9'h000, 10'd100, 0);
    set_vec(2, "halt_vs_br", 10'd8,    0, 0, 1, 1, 10'd100, 9'h1FF, 10'd8,   1);
    set_vec(3, "wrap_inc",   10'd1023, 0, 0, 0, 0, 10'd0,   9'h000, 10'd0,   0);
    set_vec(4, "wrap_rel",   10'd1020, 0, 0, 1, 0, 10'd8,   9'h000, 10'd4,   0);
    set_vec(5, "stall_halt", 10'd7,    0, 1, 0, 0, 10'd0,   9'h1FF, 10'd7,   0);
    set_vec(6, "stall_br",   10'd7,    0, 1, 1, 1, 10'd300, 9'h000, 10'd7,   0);
    set_vec(7, "seq_inc",    10'd5,    0, 0, 0, 0, 10'd0,   9'h000, 10'd6,   0);
    set_vec(8, "start_run",  10'd3,    1, 0, 0, 0, 10'd0,   9'h000, 10'd4,   0);

    idle_inputs();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    step();
    expect_obs("reset_state", 10'd0, 0, 0, 0);
    check_obs();
    check_cnt("reset_cnt", 16'd0);

    for (int i = 0; i < 9; i++) begin
      idle_inputs();
      do_reset();
      start_run(vecs[i].pc0);
      bus.start      = vecs[i].start;
      bus.start_addr = 10'd50;
      bus.stall      = vecs[i].stall;
      bus.branch_en  = vecs[i].br_en;
      bus.branch_abs = vecs[i].br_abs;
      bus.target     = vecs[i].tgt;
      inst_force     = vecs[i].inst;
      expect_obs(vecs[i].name, vecs[i].exp_pc, !vecs[i].exp_done, !vecs[i].exp_done,
                 vecs[i].exp_done);
      step();
      check_obs();
    end

    // Asynchronous reset mid-run takes effect between edges.
    idle_inputs();
    do_reset();
    start_run(10'd5);
    #2;
    rst = 1'b1;
    #1;
    expect_obs("rst_midrun", 10'd0, 0, 0, 0);
    check_obs();
    rst = 1'b0;
    step();
    step();
    expect_obs("rst_stay_idle", 10'd0, 0, 0, 0);
    check_obs();

    // Straight-line program from ROM ending in the halt word.
    idle_inputs();
    do_reset();
    use_rom = 1'b1;
    start_run(10'd0);
    expect_obs("prog_pc0", 10'd0, 1, 1, 0);
    check_obs();
    for (int i = 1; i <= 4; i++) begin
      step();
      expect_obs("prog_pc", 10'(i), 1, 1, 0);
      check_obs();
    end
    step();
    expect_obs("prog_done", 10'd4, 0, 0, 1);
    check_obs();
    check_cnt("prog_cnt", CntEn ? 16'd5 : 16'd0);
    step();
    expect_obs("prog_done_hold", 10'd4, 0, 0, 1);
    check_obs();

    // Start while in DONE restarts at a new address with a cleared counter.
    use_rom    = 1'b0;
    inst_force = 9'h000;
    start_run(10'd20);
    expect_obs("restart", 10'd20, 1, 1, 0);
    check_obs();
    check_cnt("restart_cnt", 16'd0);
    step();
    check_cnt("restart_cnt1", CntEn ? 16'd1 : 16'd0);

    // Three stall cycles hold the PC for four observed cycles.
    idle_inputs();
    do_reset();
    start_run(10'd7);
    bus.stall = 1'b1;
    expect_obs("stall_pc0", 10'd7, 1, 1, 0);
    check_obs();
    for (int i = 0; i < 3; i++) begin
      step();
      expect_obs("stall_hold", 10'd7, 1, 1, 0);
      check_obs();
    end
    bus.stall = 1'b0;
    step();
    expect_obs("stall_release", 10'd8, 1, 1, 0);
    check_obs();

    // Halt word under stall only completes once stall drops.
    idle_inputs();
    do_reset();
    start_run(10'd7);
    inst_force = 9'h1FF;
    bus.stall  = 1'b1;
    step();
    expect_obs("stall_halt_wait", 10'd7, 1, 1, 0);
    check_obs();
    bus.stall = 1'b0;
    step();
    expect_obs("stall_halt_done", 10'd7, 0, 0, 1);
    check_obs();
    check_cnt("stall_halt_cnt", CntEn ? 16'd2 : 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc.md
Name: fetch_pc

Overview:
- Program counter and fetch sequencer; sits directly upstream of the instruction ROM and drives its address input every cycle.
- Receives the combinational ROM word back, detects the halt word, and applies stall and branch (absolute or PC-relative) redirection from the decode/execute stage.
- Provides the start/done handshake to the testbench or top level, plus an optional run-cycle counter.

Parameters:
- A, 10, instruction address width; ROM depth is 2**A.
- W, 9, instruction word width.
- HALT_WORD, all ones of W bits (9'h1FF), encoding that ends program execution.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  begin execution at StartAddr; sampled in IDLE and DONE only.
- StartAddr  input  A  first instruction address loaded on Start.
- Stall  input  1  hold PC this cycle.
- BranchEn  input  1  redirect PC this cycle.
- BranchAbs  input  1  1 = Target is an absolute address; 0 = Target is a two's-complement offset from the current PC.
- Target  input  A  branch address or signed offset.
- InstIn  input  W  instruction word returned by the ROM for InstAddress (same cycle, combinational).
- InstAddress  output  A  current PC, registered; drives the ROM address.
- Valid  output  1  InstIn is a live instruction for decode this cycle.
- Busy  output  1  program running.
- Done  output  1  halt reached; level signal.
- CycleCount  output  16  RUN-state cycle count (see Optional Feature).

Behaviour:
- Reset (async, any state, mid-run included): state = IDLE, PC = 0, CycleCount = 0. Outputs take effect immediately: InstAddress = 0, Valid = 0, Busy = 0, Done = 0.
- States: IDLE, RUN, DONE. Valid and Busy are 1 only in RUN; Done is 1 only in DONE. All three decode directly from the state register.
- IDLE:
  - Start = 1: PC <= StartAddr, CycleCount <= 0, go to RUN.
  - Otherwise hold.
- RUN, evaluated each cycle in priority order:
  1. Stall = 1: PC holds. Halt detection and branch are suppressed.
  2. InstIn == HALT_WORD: go to DONE. PC holds at the halt address. Halt overrides BranchEn.
  3. BranchEn = 1: if BranchAbs, PC <= Target; else PC <= (PC + Target) mod 2**A, with Target treated as signed A-bit.
  4. Otherwise: PC <= PC + 1 mod 2**A, so 2**A-1 wraps to 0.
- Start is ignored while in RUN.
- DONE:
  - PC and CycleCount hold; Done stays high until Start.
  - Start = 1: PC <= StartAddr, CycleCount <= 0, go to RUN. Done drops on the next edge.
- Latency:
  - A new PC appears on InstAddress one edge after the decision.
  - An instruction at PC is presented with Valid = 1 for exactly one non-stalled RUN cycle.
- All PC arithmetic is A-bit modular; no overflow flag.

Optional Feature:
- Macro: FETCH_PC_CYCLE_CNT_EN.
- Defined:
  - CycleCount increments by 1 on every RUN cycle, stall cycles included; the cycle that detects halt is counted.
  - Saturates at 16'hFFFF.
  - Cleared on Start and on Reset; held in IDLE and DONE.
- Undefined: the counter logic is absent and CycleCount is tied to 16'h0000. Port list is unchanged.

Test Plan:
- Reset mid-run: RUN with PC = 5, assert Reset between edges -> InstAddress = 0, Valid = 0, Busy = 0, Done = 0 immediately; after release, state stays IDLE with no Start.
- Straight-line program: ROM[0..3] non-halt, ROM[4] = 9'h1FF, Start with StartAddr = 0 -> InstAddress = 0,1,2,3,4 on consecutive cycles; Done = 1 from the next edge; InstAddress holds 4; CycleCount = 5 with macro, 0 without.
- Branches:
  - PC = 10, BranchEn = 1, BranchAbs = 0, Target = 10'h3FE -> next PC = 8.
  - PC = 8, BranchAbs = 1, Target = 100 -> next PC = 100.
  - BranchEn together with InstIn = 9'h1FF -> DONE, PC unchanged.
- Wrap: PC = 1023 with no branch -> PC = 0; PC = 1020 with relative Target = 8 -> PC = 4.
- Stall:
  - PC = 7, Stall high for 3 cycles -> InstAddress = 7 for 4 cycles, then 8.
  - Stall high while InstIn = 9'h1FF -> no Done until Stall drops, then DONE on that edge.
- Handshake: Start pulsed during RUN -> ignored, PC unaffected. Start in DONE with StartAddr = 20 -> RUN, InstAddress = 20, Done = 0, CycleCount restarts from 0.
